imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried with each instruction.
REQ-003 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port FLUSH, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have ports IN_VALID (input, 1) and IN_READY (output, 1) as the upstream handshake.
REQ-007 SHALL have port INSTRUCTION, input, 32, raw instruction word.
REQ-008 SHALL have port SELECT, input, 3, format: 0 I, 1 S, 2 U, 3 B, 4 J, 5 Z (CSR zimm), 6-7 invalid.
REQ-009 SHALL have port IN_TAG, input, TAG_W, sideband tag.
REQ-010 SHALL have ports OUT_VALID (output, 1) and OUT_READY (input, 1) as the downstream handshake.
REQ-011 SHALL have ports OUT (output, XLEN, immediate), OUT_TAG (output, TAG_W) and OUT_ERR (output, 1, invalid format).

Function
REQ-012 Transfer occurs on a rising edge with VALID and READY both high; upstream data sampled only on a transfer.
REQ-013 Immediate SHALL be computed combinationally from the input and registered: one-cycle latency from input transfer to OUT_VALID when empty.
REQ-014 I: sign-extend INSTRUCTION[31:20]; if opcode 0010011 and funct3 001 or 101, zero-extend shamt instead: [24:20] for XLEN=32, [25:20] for XLEN=64; opcode 0011011 (XLEN=64 only) uses [24:20].
REQ-015 S: sign-extend {[31:25],[11:7]}; B: sign-extend {[31],[7],[30:25],[11:8],0}; J: sign-extend {[31],[19:12],[20],[30:21],0}.
REQ-016 U: {[31:12],12'b0}, sign-extended from bit 31 to XLEN; Z: zero-extend [19:15].
REQ-017 SELECT 6 or 7: OUT=0, OUT_ERR=1; otherwise OUT_ERR=0.
REQ-018 Storage: output register plus one skid register; IN_READY SHALL equal not(skid valid), registered, no combinational path from OUT_READY.
REQ-019 Output stalled (OUT_VALID=1, OUT_READY=0) and input transfer: entry goes to skid; IN_READY low next cycle.
REQ-020 Output fires with skid valid: skid moves to output same edge; IN_READY high next cycle.
REQ-021 Output fires with skid empty and input transfer same edge: new entry loads output directly; sustained throughput one per cycle.
REQ-022 OUT, OUT_TAG, OUT_ERR SHALL remain stable while OUT_VALID=1 and OUT_READY=0; order preserved.
REQ-023 FLUSH=1: both entries invalidated next edge; a simultaneous input transfer SHALL be dropped (flush wins).

Reset
REQ-024 RESET_N low SHALL immediately force OUT_VALID=0, OUT=0, OUT_TAG=0, OUT_ERR=0, skid empty, IN_READY=0.
REQ-025 IN_READY SHALL go to 1 on the first rising edge after RESET_N deasserts; reset mid-operation discards all entries.

Configuration
REQ-026 Macro IMM_AUTO_DECODE_EN defined: SELECT ignored; format derived from opcode: 0010011/0000011/1100111/0011011 I, 0100011 S, 0110111/0010111 U, 1100011 B, 1101111 J, 1110011 with funct3[2]=1 Z else I, any other opcode OUT=0 OUT_ERR=1.
REQ-027 Macro not defined: format taken from SELECT per REQ-008; SELECT port present in both builds.

Verification
REQ-028 XLEN=32, SELECT=0, INSTRUCTION=0xFFF00093 -> OUT=0xFFFFFFFF one cycle later; 0x4030D093 (srai) -> OUT=0x00000003.
REQ-029 SELECT=3, INSTRUCTION=0xFE000EE3 -> OUT=0xFFFFFFFC, OUT_ERR=0; SELECT=6 -> OUT=0, OUT_ERR=1.
REQ-030 XLEN=64, SELECT=2, INSTRUCTION=0x800000B7 -> OUT=0xFFFFFFFF80000000.
REQ-031 OUT_READY=0, send tags 1,2 -> IN_READY=0 after second; OUT_READY=1 -> tag 1 then tag 2 on consecutive cycles, IN_READY=1.
REQ-032 Stream 8 instructions, OUT_READY=1 -> 8 outputs on 8 consecutive cycles; FLUSH or RESET_N low mid-stream -> OUT_VALID=0 next edge (reset: immediately), no stale output.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Purpose:
//   Immediate generator with a two-entry elastic pipeline (output register
//   plus one skid register). The immediate is decoded combinationally from
//   the incoming instruction word and captured on an upstream transfer. It
//   then flows out with valid/ready backpressure, and order is preserved.
//
// Ports:
//   CLK          sole clock, rising edge
//   RESET_N      asynchronous active-low reset
//   FLUSH        synchronous discard of all held entries (wins over input)
//   IN_VALID     upstream valid
//   IN_READY     upstream ready (registered, equals "skid register empty")
//   INSTRUCTION  raw 32-bit instruction word
//   SELECT       format: 0 I, 1 S, 2 U, 3 B, 4 J, 5 Z (CSR zimm), 6-7 invalid
//   IN_TAG       sideband tag travelling with the instruction
//   OUT_VALID    downstream valid
//   OUT_READY    downstream ready
//   OUT          XLEN-bit immediate
//   OUT_TAG      tag of the entry on OUT
//   OUT_ERR      entry had an invalid format (OUT is 0)
//
// Build option:
//   IMM_AUTO_DECODE_EN  when defined, SELECT is ignored and the format is
//                       derived from the opcode field. The SELECT port stays
//                       in the port list for both builds.
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [2:0]       SELECT,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  OUT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ERR
);

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_U   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_Z   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd6;

    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            shift_f3;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            imm_err;

    assign opcode   = INSTRUCTION[6:0];
    assign funct3   = INSTRUCTION[14:12];
    // funct3 001/101 under OP-IMM encodes shifts; their immediate is a shamt.
    assign shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

    // -----------------------------------------------------------------------
    // Format selection
    // -----------------------------------------------------------------------
`ifdef IMM_AUTO_DECODE_EN
    always_comb begin
        fmt = FMT_BAD;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: fmt = FMT_I;
            7'b0100011:                                     fmt = FMT_S;
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1100011:                                     fmt = FMT_B;
            7'b1101111:                                     fmt = FMT_J;
            // SYSTEM: funct3[2] set marks the immediate CSR forms (zimm).
            7'b1110011:                                     fmt = funct3[2] ? FMT_Z : FMT_I;
            default:                                        fmt = FMT_BAD;
        endcase
    end
`else
    assign fmt = SELECT;
`endif

    // -----------------------------------------------------------------------
    // Immediate decode. Size casts of $signed operands sign-extend to XLEN.
    // -----------------------------------------------------------------------
    always_comb begin
        imm     = '0;
        imm_err = 1'b0;
        case (fmt)
            FMT_I: begin
                if (opcode == OP_OP_IMM && shift_f3) begin
                    if (XLEN == 64) imm = XLEN'(INSTRUCTION[25:20]);
                    else            imm = XLEN'(INSTRUCTION[24:20]);
                end else if (XLEN == 64 && opcode == OP_OP_IMM_32 && shift_f3) begin
                    // *W shifts operate on 32 bits, so only a 5-bit shamt.
                    imm = XLEN'(INSTRUCTION[24:20]);
                end else begin
                    imm = XLEN'($signed(INSTRUCTION[31:20]));
                end
            end
            FMT_S: imm = XLEN'($signed({INSTRUCTION[31:25], INSTRUCTION[11:7]}));
            FMT_U: imm = XLEN'($signed({INSTRUCTION[31:12], 12'b0}));
            FMT_B: imm = XLEN'($signed({INSTRUCTION[31], INSTRUCTION[7],
                                         INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0}));
            FMT_J: imm = XLEN'($signed({INSTRUCTION[31], INSTRUCTION[19:12],
                                         INSTRUCTION[20], INSTRUCTION[30:21], 1'b0}));
            FMT_Z: imm = XLEN'(INSTRUCTION[19:15]);
            default: begin
                imm     = '0;
                imm_err = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Elastic storage: output register + skid register
    // -----------------------------------------------------------------------
    logic             out_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;
    logic             skid_valid_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_err_q;
    logic             in_ready_q;

    logic in_fire;
    logic out_free;
    logic skid_valid_d;

    assign in_fire  = IN_VALID && in_ready_q;
    // Output register can take a new entry this edge: empty or draining.
    assign out_free = !out_valid_q || OUT_READY;

    // IN_READY is the registered inverse of the next skid occupancy, so it
    // never depends combinationally on OUT_READY.
    always_comb begin
        skid_valid_d = skid_valid_q;
        if (FLUSH)         skid_valid_d = 1'b0;
        else if (out_free) skid_valid_d = 1'b0;
        else if (in_fire)  skid_valid_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            in_ready_q   <= !skid_valid_d;
            skid_valid_q <= skid_valid_d;
            if (FLUSH) begin
                out_valid_q <= 1'b0;
            end else if (out_free) begin
                if (skid_valid_q) begin
                    // Skid is older than anything upstream; it goes first.
                    out_valid_q <= 1'b1;
                    out_imm_q   <= skid_imm_q;
                    out_tag_q   <= skid_tag_q;
                    out_err_q   <= skid_err_q;
                end else if (in_fire) begin
                    out_valid_q <= 1'b1;
                    out_imm_q   <= imm;
                    out_tag_q   <= IN_TAG;
                    out_err_q   <= imm_err;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (in_fire) begin
                skid_imm_q <= imm;
                skid_tag_q <= IN_TAG;
                skid_err_q <= imm_err;
            end
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT       = out_imm_q;
    assign OUT_TAG   = out_tag_q;
    assign OUT_ERR   = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      instruction = '0;
    logic [2:0]       sel = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;

    logic             in_ready32, out_valid32, out_err32;
    logic [31:0]      out32;
    logic [TAG_W-1:0] out_tag32;
    logic             in_ready64, out_valid64, out_err64;
    logic [63:0]      out64;
    logic [TAG_W-1:0] out_tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready32),
        .INSTRUCTION(instruction), .SELECT(sel), .IN_TAG(in_tag),
        .OUT_VALID(out_valid32), .OUT_READY(out_ready),
        .OUT(out32), .OUT_TAG(out_tag32), .OUT_ERR(out_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .CLK(clk), .RESET_N(rst_n), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready64),
        .INSTRUCTION(instruction), .SELECT(sel), .IN_TAG(in_tag),
        .OUT_VALID(out_valid64), .OUT_READY(out_ready),
        .OUT(out64), .OUT_TAG(out_tag64), .OUT_ERR(out_err64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      e32;
        logic [63:0]      e64;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   fresh    = 1'b1;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference immediate computed with signed integer arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] s,
                                            input bit x64, output logic err);
        longint     v;
        int         fmt;
        logic [6:0] op;
        logic [2:0] f3;
        bit         sh;
        v  = 0;
        op = ins[6:0];
        f3 = ins[14:12];
        sh = (f3 == 3'd1) || (f3 == 3'd5);
`ifdef IMM_AUTO_DECODE_EN
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: fmt = 0;
            7'b0100011:             fmt = 1;
            7'b0110111, 7'b0010111: fmt = 2;
            7'b1100011:             fmt = 3;
            7'b1101111:             fmt = 4;
            7'b1110011:             fmt = f3[2] ? 5 : 0;
            default:                fmt = 6;
        endcase
`else
        fmt = int'(s);
`endif
        err = (fmt >= 6);
        case (fmt)
            0: begin
                if (op == 7'b0010011 && sh)
                    v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
                else if (x64 && op == 7'b0011011 && sh)
                    v = longint'(ins[24:20]);
                else
                    v = longint'($signed(ins)) >>> 20;
            end
            1: v = (longint'($signed(ins)) >>> 25) * 32 + longint'(ins[11:7]);
            2: v = (longint'($signed(ins)) >>> 12) * 4096;
            3: v = (ins[31] ? -64'sd4096 : 64'sd0) + 2048 * longint'(ins[7])
                   + 32 * longint'(ins[30:25]) + 2 * longint'(ins[11:8]);
            4: v = (ins[31] ? -64'sd1048576 : 64'sd0) + 4096 * longint'(ins[19:12])
                   + 2048 * longint'(ins[20]) + 2 * longint'(ins[30:21]);
            5: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // One clock: scoreboard checks at negedge, model update for the coming
    // edge, then return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        bit   mready, in_fire, out_fire;
        logic er;
        @(negedge clk);
        mready = rst_n && !fresh && (q.size() < 2);
        chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
        chk("in_ready32", 64'(in_ready32), 64'(mready));
        chk("in_ready64", 64'(in_ready64), 64'(mready));
        if (q.size() != 0) begin
            e = q[0];
            chk("sb_out32", 64'(out32), e.e32);
            chk("sb_out64", out64, e.e64);
            chk("sb_tag32", 64'(out_tag32), 64'(e.tag));
            chk("sb_tag64", 64'(out_tag64), 64'(e.tag));
            chk("sb_err32", 64'(out_err32), 64'(e.err));
            chk("sb_err64", 64'(out_err64), 64'(e.err));
        end
        if (rst_n) begin
            in_fire  = in_valid && mready;
            out_fire = (q.size() != 0) && out_ready;
            if (out_fire) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_fire) begin
                e.e32 = ref_imm(instruction, sel, 1'b0, er);
                e.e64 = ref_imm(instruction, sel, 1'b1, er);
                e.tag = in_tag;
                e.err = er;
                q.push_back(e);
            end
        end
        @(posedge clk);
        if (rst_n) fresh = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_out", 64'(out32), 64'd0);
        chk("rst_out64", out64, 64'd0);
        chk("rst_tag", 64'(out_tag32), 64'd0);
        chk("rst_err", 64'(out_err32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd0);
        q.delete();
        fresh    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_chk(input logic [31:0] ins, input logic [2:0] s,
                            input logic [63:0] x32, input logic [63:0] x64, input logic xerr);
        in_valid    = 1'b1;
        instruction = ins;
        sel         = s;
        in_tag      = TAG_W'($urandom);
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("dir_valid", 64'(out_valid32), 64'd1);
        chk("dir_out32", 64'(out32), x32);
        chk("dir_out64", out64, x64);
        chk("dir_err", 64'(out_err32), 64'(xerr));
        tick();
    endtask

    initial begin
        apply_reset();

        send_chk(32'hFFF0_0093, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_chk(32'h4030_D093, 3'd0, 64'd3, 64'd3, 1'b0);
        send_chk(32'h43F0_D093, 3'd0, 64'd31, 64'd63, 1'b0);
        send_chk(32'hFE00_0EE3, 3'd3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send_chk(32'h8000_00B7, 3'd2, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
`ifndef IMM_AUTO_DECODE_EN
        send_chk(32'hFE00_0EE3, 3'd6, 64'd0, 64'd0, 1'b1);
`endif

        // Backpressure: two entries held, then drained back to back.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = $urandom;
        sel         = 3'd0;
        in_tag      = TAG_W'(1);
        tick();
        in_tag      = TAG_W'(2);
        instruction = $urandom;
        tick();
        in_valid = 1'b0;
        chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
        chk("bp_head_tag", 64'(out_tag32), 64'd1);
        tick();
        chk("bp_hold_tag", 64'(out_tag32), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_second_tag", 64'(out_tag32), 64'd2);
        chk("bp_second_valid", 64'(out_valid32), 64'd1);
        chk("bp_in_ready_high", 64'(in_ready32), 64'd1);
        tick();
        chk("bp_drained", 64'(out_valid32), 64'd0);

        // Full-throughput stream.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid    = 1'b1;
            instruction = $urandom;
            sel         = 3'($urandom_range(0, 5));
            in_tag      = TAG_W'(i);
            tick();
            chk("stream_valid", 64'(out_valid32), 64'd1);
            chk("stream_tag", 64'(out_tag32), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end", 64'(out_valid32), 64'd0);

        // Flush mid-stream; the simultaneous input is dropped.
        for (int i = 0; i < 4; i++) begin
            in_valid    = 1'b1;
            instruction = $urandom;
            sel         = 3'($urandom_range(0, 5));
            in_tag      = TAG_W'(i + 10);
            tick();
        end
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid32), 64'd0);
        tick();
        chk("flush_no_stale", 64'(out_valid32), 64'd0);

        // Flush with both entries held under backpressure.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid    = 1'b1;
            instruction = $urandom;
            in_tag      = TAG_W'(i + 20);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_full_valid", 64'(out_valid32), 64'd0);
        chk("flush_full_ready", 64'(in_ready32), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            instruction = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                instruction[6:0]   = ($urandom_range(0, 1) == 0) ? 7'b0010011 : 7'b0011011;
                instruction[14:12] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
            end
            sel       = 3'($urandom_range(0, 7));
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        // Reset mid-stream.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            instruction = $urandom;
            sel         = 3'($urandom_range(0, 5));
            in_tag      = TAG_W'(i);
            tick();
        end
        apply_reset();
        send_chk(32'hFFF0_0093, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
